// File: rtl/multiport_line_adapter_pkg.sv
// Shared definitions for the line adapter: controller states and the
// beat/index width helpers used to size counters from module parameters.
package multiport_line_adapter_pkg;

  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RESP
  } state_t;

  function automatic int beats_of(input int line_w, input int bus_w);
    return line_w / bus_w;
  endfunction

  // Index width that stays at least 1 bit for single-entry cases.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request selector. The pointer only moves when the owner of a
// grant reports completion, so an unaccepted grant can change freely.
module rr_arbiter #(
  parameter int NCH = 2,
  parameter int IW  = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req,
  input  logic           advance,
  input  logic [IW-1:0]  last,
  output logic [NCH-1:0] grant,
  output logic [IW-1:0]  grant_idx
);

  logic [IW-1:0] ptr;
  int            cand;

  // Scan from farthest to nearest offset so the closest requester to ptr wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = 0;
    for (int i = NCH - 1; i >= 0; i--) begin
      cand = int'(ptr) + i;
      if (cand >= NCH) cand = cand - NCH;
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        grant_idx   = IW'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(last) == NCH - 1) ? '0 : last + 1'b1;
    end
  end

endmodule

// File: rtl/multiport_line_adapter.sv
// Serialises whole-line read/write requests from several caches onto one
// beat-wide memory port, collecting or emitting BEATS beats per line.
module multiport_line_adapter
  import multiport_line_adapter_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int LINE_W = 256,
  parameter int BUS_W  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH*32-1:0]     dfp_addr,
  input  logic [NCH-1:0]        dfp_read,
  input  logic [NCH-1:0]        dfp_write,
  input  logic [NCH*LINE_W-1:0] dfp_wdata,
  output logic [NCH*LINE_W-1:0] dfp_rdata,
  output logic [NCH-1:0]        dfp_resp,
  output logic [31:0]           bmem_addr,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [BUS_W-1:0]      bmem_wdata,
  input  logic                  bmem_ready,
  input  logic [31:0]           bmem_raddr,
  input  logic [BUS_W-1:0]      bmem_rdata,
  input  logic                  bmem_rvalid,
  output logic                  err
);

  localparam int BEATS = beats_of(LINE_W, BUS_W);
  localparam int BCW   = idx_w(BEATS);
  localparam int IW    = idx_w(NCH);

  state_t            state;
  logic [IW-1:0]     gnt_q;
  logic [31:0]       addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] line_q;
  logic [BCW-1:0]    beat_cnt;

  logic [NCH-1:0]    arb_grant;
  logic [IW-1:0]     arb_idx;
  logic              arb_any;
  logic              win_rd;
  logic [31:0]       win_addr;

  rr_arbiter #(.NCH(NCH), .IW(IW)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (dfp_read | dfp_write),
    .advance   (state == S_RESP),
    .last      (gnt_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  assign arb_any   = |arb_grant;
  assign win_rd    = |(dfp_read & arb_grant);
  assign win_addr  = dfp_addr[arb_idx*32 +: 32];
  assign dfp_rdata = {NCH{line_q}};

  // The idle command is offered combinationally so memory can accept it at once.
  always_comb begin
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_addr  = addr_q;
    bmem_wdata = wdata_q[beat_cnt*BUS_W +: BUS_W];
    case (state)
      S_IDLE: begin
        bmem_addr  = win_addr & ~(32'(LINE_W / 8) - 32'd1);
        bmem_wdata = dfp_wdata[arb_idx*LINE_W +: BUS_W];
        bmem_read  = arb_any & win_rd & ~rst;
        bmem_write = arb_any & ~win_rd & ~rst;
      end
      S_WR:    bmem_write = ~rst;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      gnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      line_q   <= '0;
      beat_cnt <= '0;
      err      <= 1'b0;
      dfp_resp <= '0;
    end else begin
      dfp_resp <= '0;
      case (state)
        S_IDLE: begin
          if (arb_any && bmem_ready) begin
            gnt_q   <= arb_idx;
            addr_q  <= bmem_addr;
            wdata_q <= dfp_wdata[arb_idx*LINE_W +: LINE_W];
            if (win_rd) begin
              state    <= S_RD;
              beat_cnt <= '0;
            end else begin
              state    <= S_WR;
              beat_cnt <= BCW'(1);
            end
          end
        end
        S_RD: begin
          if (bmem_rvalid) begin
            if (bmem_raddr == addr_q) begin
              line_q[beat_cnt*BUS_W +: BUS_W] <= bmem_rdata;
              beat_cnt <= beat_cnt + 1'b1;
              if (beat_cnt == BCW'(BEATS - 1)) begin
                state    <= S_RESP;
                dfp_resp <= NCH'(1) << gnt_q;
              end
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_WR: begin
          if (bmem_ready) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == BCW'(BEATS - 1)) begin
              state    <= S_RESP;
              dfp_resp <= NCH'(1) << gnt_q;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiport_line_adapter.sv
// Bench for the line adapter: a 2-channel 256-bit instance for directed and
// table cases, and a 4-channel 512-bit instance under random traffic.
module tb_multiport_line_adapter;

  localparam int NA = 2, LW = 256, BW = 64;
  localparam int NB = 4, LWB = 512, BEATS_B = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- instance A ----------------
  logic              rst;
  logic [NA*32-1:0]  dfp_addr;
  logic [NA-1:0]     dfp_read, dfp_write, dfp_resp;
  logic [NA*LW-1:0]  dfp_wdata, dfp_rdata;
  logic [31:0]       bmem_addr, bmem_raddr;
  logic              bmem_read, bmem_write, bmem_ready, bmem_rvalid, err;
  logic [BW-1:0]     bmem_wdata, bmem_rdata;

  multiport_line_adapter #(.NCH(NA), .LINE_W(LW), .BUS_W(BW)) dut_a (
    .clk(clk), .rst(rst), .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid), .err(err)
  );

  // ---------------- instance B ----------------
  logic              rst_b;
  logic [NB*32-1:0]  b_addr;
  logic [NB-1:0]     b_read, b_write, b_resp;
  logic [NB*LWB-1:0] b_wdata, b_rdata;
  logic [31:0]       b_bmem_addr, b_raddr;
  logic              b_bmem_read, b_bmem_write, b_ready, b_rvalid, err_b;
  logic [BW-1:0]     b_bmem_wdata, b_rdata_beat;

  multiport_line_adapter #(.NCH(NB), .LINE_W(LWB), .BUS_W(BW)) dut_b (
    .clk(clk), .rst(rst_b), .dfp_addr(b_addr), .dfp_read(b_read), .dfp_write(b_write),
    .dfp_wdata(b_wdata), .dfp_rdata(b_rdata), .dfp_resp(b_resp),
    .bmem_addr(b_bmem_addr), .bmem_read(b_bmem_read), .bmem_write(b_bmem_write),
    .bmem_wdata(b_bmem_wdata), .bmem_ready(b_ready), .bmem_raddr(b_raddr),
    .bmem_rdata(b_rdata_beat), .bmem_rvalid(b_rvalid), .err(err_b)
  );

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- A monitors / scoreboard ----------------
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] wr_log[$];
  int            resp_log[$];

  always @(posedge clk) if (!rst && bmem_write && bmem_ready) wr_log.push_back(bmem_wdata);
  always @(negedge clk)
    for (int c = 0; c < NA; c++) if (dfp_resp[c]) resp_log.push_back(c);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_quiet();
    dfp_read = '0; dfp_write = '0; bmem_ready = 1'b0;
    bmem_rvalid = 1'b0; bmem_raddr = '0; bmem_rdata = '0;
  endtask

  task automatic a_reset();
    rst = 1'b1;
    a_quiet();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] ra, input logic [BW-1:0] d);
    bmem_rvalid = 1'b1; bmem_raddr = ra; bmem_rdata = d;
    tick();
    bmem_rvalid = 1'b0;
  endtask

  // ---------------- B memory model and reference ----------------
  logic [LWB-1:0] mem_b  [logic [31:0]];
  logic [LWB-1:0] ref_mem[logic [31:0]];

  function automatic logic [LWB-1:0] init_line(input logic [31:0] a);
    logic [LWB-1:0] l;
    for (int i = 0; i < BEATS_B; i++) l[i*64 +: 64] = {a, 32'hC0DE_0000 ^ 32'(i)};
    return l;
  endfunction

  function automatic logic [LWB-1:0] mem_line(input logic [31:0] a);
    return mem_b.exists(a) ? mem_b[a] : init_line(a);
  endfunction

  function automatic logic [LWB-1:0] ref_line(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
  endfunction

  initial begin : mem_b_proc
    logic [LWB-1:0] wbuf, rl;
    logic [31:0]    rline;
    int             wcnt, rcnt;
    bit             rd_pend, acc_rd, acc_wr, rv_sent;
    b_ready = 1'b0; b_rvalid = 1'b0; b_raddr = '0; b_rdata_beat = '0;
    wbuf = '0; rl = '0; rline = '0; wcnt = 0; rcnt = 0; rd_pend = 0;
    forever begin
      @(posedge clk);
      acc_rd  = b_bmem_read && b_ready;
      acc_wr  = b_bmem_write && b_ready;
      rv_sent = b_rvalid && rd_pend;
      if (rst_b) begin
        wcnt = 0; rd_pend = 0;
      end else begin
        if (acc_wr) begin
          wbuf[wcnt*64 +: 64] = b_bmem_wdata;
          wcnt++;
          if (wcnt == BEATS_B) begin
            mem_b[b_bmem_addr] = wbuf;
            wcnt = 0;
          end
        end
        if (rv_sent) begin
          rcnt++;
          if (rcnt == BEATS_B) rd_pend = 0;
        end
        if (acc_rd) begin
          rd_pend = 1; rcnt = 0; rline = b_bmem_addr;
        end
      end
      #1;
      b_ready = ($urandom_range(0, 3) != 0);
      if (rd_pend && $urandom_range(0, 3) != 0) begin
        rl = mem_line(rline);
        b_rvalid = 1'b1; b_raddr = rline; b_rdata_beat = rl[rcnt*64 +: 64];
      end else if (!rd_pend && $urandom_range(0, 7) == 0) begin
        // Stray beat while no read is outstanding; the adapter must ignore it.
        b_rvalid = 1'b1; b_raddr = 32'hDEAD_0000; b_rdata_beat = '1;
      end else begin
        b_rvalid = 1'b0;
      end
    end
  end

  bit b_burst = 0, b_rand = 0;
  int b_done = 0;
  int b_order[$];
  bit b_active[NB];

  initial begin : req_b_proc
    logic [31:0]    line[NB];
    logic [LWB-1:0] wd[NB];
    bit             op_rd[NB];
    int             waits[NB];
    bit             burst_done;
    logic [31:0]    a;
    burst_done = 0;
    b_read = '0; b_write = '0; b_addr = '0; b_wdata = '0;
    for (int c = 0; c < NB; c++) begin
      b_active[c] = 0; waits[c] = 0; op_rd[c] = 0; line[c] = '0; wd[c] = '0;
    end
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        for (int c = 0; c < NB; c++) begin
          if (b_resp[c]) begin
            b_done++;
            b_order.push_back(c);
            check("b_resp_onehot", 512'($countones(b_resp)), 512'd1);
            check("b_wait_bound", 512'(waits[c] <= NB - 1), 512'd1);
            if (op_rd[c]) begin
              check("b_rdata", b_rdata[c*LWB +: LWB], ref_line(line[c]));
            end else begin
              ref_mem[line[c]] = wd[c];
              check("b_mem_line", mem_line(line[c]), wd[c]);
            end
            for (int o = 0; o < NB; o++) if (o != c && b_active[o]) waits[o]++;
            b_active[c] = 0; b_read[c] = 1'b0; b_write[c] = 1'b0;
          end
        end
        for (int c = 0; c < NB; c++) begin
          if (!b_active[c] && ((b_burst && !burst_done) || (b_rand && $urandom_range(0, 3) == 0))) begin
            b_active[c] = 1; waits[c] = 0;
            op_rd[c] = (b_burst && !burst_done) ? 1'b0 : 1'($urandom_range(0, 1));
            a = 32'h4000_0000 + 32'($urandom_range(0, 5) << 6) + 32'($urandom_range(0, 63));
            line[c] = a & ~32'd63;
            for (int k = 0; k < LWB / 32; k++) wd[c][k*32 +: 32] = $urandom();
            b_addr[c*32 +: 32] = a;
            b_wdata[c*LWB +: LWB] = wd[c];
            b_read[c]  = op_rd[c];
            // A read sometimes also carries write; it must still be served as a read.
            b_write[c] = !op_rd[c] || ($urandom_range(0, 3) == 0);
          end
        end
        if (b_burst) burst_done = 1;
      end
    end
  end

  // ---------------- table of idle command vectors ----------------
  typedef struct {
    logic [1:0]  rd, wr;
    logic [31:0] a0, a1;
    logic        exp_rd, exp_wr;
    logic [31:0] exp_addr;
    logic [63:0] exp_wd;
  } vec_t;

  vec_t vecs[7];

  logic [LW-1:0] wline0, wline1;
  logic [63:0]   ba, bb, bc, bd;

  initial begin : main
    int cyc, snap;
    wline0 = {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2, 64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0};
    wline1 = {64'hB3B3_B3B3_B3B3_B3B3, 64'hB2B2_B2B2_B2B2_B2B2, 64'hB1B1_B1B1_B1B1_B1B1, 64'hB0B0_B0B0_B0B0_B0B0};
    vecs[0] = '{2'b01, 2'b00, 32'h1000_0024, 32'h0,         1'b1, 1'b0, 32'h1000_0020, 64'h0};
    vecs[1] = '{2'b00, 2'b10, 32'h0,         32'h2000_005F, 1'b0, 1'b1, 32'h2000_0040, 64'hB0B0_B0B0_B0B0_B0B0};
    vecs[2] = '{2'b01, 2'b01, 32'h1000_0044, 32'h0,         1'b1, 1'b0, 32'h1000_0040, 64'h0};
    vecs[3] = '{2'b10, 2'b01, 32'h0000_0008, 32'h0000_1000, 1'b0, 1'b1, 32'h0000_0000, 64'hA0A0_A0A0_A0A0_A0A0};
    vecs[4] = '{2'b00, 2'b00, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 32'h0,         64'h0};
    vecs[5] = '{2'b10, 2'b10, 32'h0,         32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFE0, 64'h0};
    vecs[6] = '{2'b00, 2'b11, 32'h1234_567F, 32'h0,         1'b0, 1'b1, 32'h1234_5660, 64'hA0A0_A0A0_A0A0_A0A0};

    rst_b = 1'b1;
    dfp_addr = '0; dfp_wdata = {wline1, wline0};
    rst = 1'b1; a_quiet();
    dfp_read = 2'b01; dfp_addr[31:0] = 32'h1000_0000;
    @(negedge clk);
    check("rst_gates_read", bmem_read, 1'b0);
    tick(); tick();
    a_reset();

    @(negedge clk);
    check("rst_resp", dfp_resp, 2'b00);
    check("rst_err", err, 1'b0);
    check("rst_rdata", dfp_rdata, '0);
    check("rst_bmem_write", bmem_write, 1'b0);

    // Idle command decode with ready low so nothing is accepted.
    for (int i = 0; i < 7; i++) begin
      dfp_read = vecs[i].rd; dfp_write = vecs[i].wr;
      dfp_addr = {vecs[i].a1, vecs[i].a0};
      @(negedge clk);
      check($sformatf("vec%0d_read", i), bmem_read, vecs[i].exp_rd);
      check($sformatf("vec%0d_write", i), bmem_write, vecs[i].exp_wr);
      if (vecs[i].exp_rd || vecs[i].exp_wr) check($sformatf("vec%0d_addr", i), bmem_addr, vecs[i].exp_addr);
      if (vecs[i].exp_wr) check($sformatf("vec%0d_wdata", i), bmem_wdata, vecs[i].exp_wd);
      tick();
    end
    a_quiet();

    // Basic read of one line.
    ba = 64'hAAAA_0000_0000_000A; bb = 64'hBBBB_0000_0000_000B;
    bc = 64'hCCCC_0000_0000_000C; bd = 64'hDDDD_0000_0000_000D;
    dfp_addr[31:0] = 32'h1000_0024; dfp_read = 2'b01; bmem_ready = 1'b1;
    @(negedge clk);
    check("rd_cmd_addr", bmem_addr, 32'h1000_0020);
    check("rd_cmd_read", bmem_read, 1'b1);
    tick();
    bmem_ready = 1'b0;
    @(negedge clk);
    check("rd_cmd_dropped", bmem_read, 1'b0);
    send_beat(32'h1000_0020, ba);
    send_beat(32'h1000_0020, bb);
    send_beat(32'h1000_0020, bc);
    @(negedge clk);
    check("rd_no_early_resp", dfp_resp, 2'b00);
    send_beat(32'h1000_0020, bd);
    @(negedge clk);
    check("rd_resp", dfp_resp, 2'b01);
    check("rd_data_ch0", dfp_rdata[LW-1:0], {bd, bc, bb, ba});
    check("rd_data_ch1", dfp_rdata[2*LW-1:LW], {bd, bc, bb, ba});
    dfp_read = 2'b00;
    tick();
    @(negedge clk);
    check("rd_resp_one_cycle", dfp_resp, 2'b00);

    // Read with a foreign beat in the middle.
    check("err_clear_before", err, 1'b0);
    dfp_addr[31:0] = 32'h1000_0060; dfp_read = 2'b01; bmem_ready = 1'b1;
    tick();
    bmem_ready = 1'b0;
    send_beat(32'h1000_0060, 64'h1);
    send_beat(32'h3000_0000, 64'hBAD0_BAD0_BAD0_BAD0);
    @(negedge clk);
    check("mismatch_err", err, 1'b1);
    send_beat(32'h1000_0060, 64'h2);
    send_beat(32'h1000_0060, 64'h3);
    send_beat(32'h1000_0060, 64'h4);
    @(negedge clk);
    check("mismatch_resp", dfp_resp, 2'b01);
    check("mismatch_data", dfp_rdata[LW-1:0], {64'h4, 64'h3, 64'h2, 64'h1});
    dfp_read = 2'b00;
    tick();

    // Write with backpressure on beat 2.
    wr_log.delete(); exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(wline1[k*64 +: 64]);
    dfp_addr[63:32] = 32'h2000_0040; dfp_write = 2'b10; bmem_ready = 1'b1;
    @(negedge clk);
    check("wr_cmd", {bmem_write, bmem_addr, bmem_wdata}, {1'b1, 32'h2000_0040, wline1[63:0]});
    tick();
    @(negedge clk);
    check("wr_beat1", {bmem_write, bmem_addr, bmem_wdata}, {1'b1, 32'h2000_0040, wline1[127:64]});
    tick();
    bmem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("wr_beat2_held", {bmem_write, bmem_wdata}, {1'b1, wline1[191:128]});
      tick();
    end
    bmem_ready = 1'b1;
    tick();
    @(negedge clk);
    check("wr_no_early_resp", dfp_resp, 2'b00);
    tick();
    bmem_ready = 1'b0;
    @(negedge clk);
    check("wr_resp", dfp_resp, 2'b10);
    check("wr_err_sticky", err, 1'b1);
    dfp_write = 2'b00;
    tick();
    check("wr_beat_count", 512'(wr_log.size()), 512'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < wr_log.size(); k++)
      check($sformatf("wr_beat_order%0d", k), wr_log[k], exp_q[k]);

    // Both channels requesting back to back must alternate.
    a_reset();
    @(negedge clk);
    check("err_cleared_by_rst", err, 1'b0);
    resp_log.delete();
    dfp_addr = {32'h5000_0020, 32'h5000_0000}; dfp_write = 2'b11; bmem_ready = 1'b1;
    cyc = 0;
    while (resp_log.size() < 6 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("rr_timeout", 512'(cyc < 100), 512'd1);
    dfp_write = 2'b00; bmem_ready = 1'b0;
    tick(); tick();
    for (int k = 0; k < 6 && k < resp_log.size(); k++)
      check($sformatf("rr_grant%0d", k), 512'(resp_log[k]), 512'(k % 2));

    // Reset in the middle of a read abandons it.
    a_reset();
    resp_log.delete();
    dfp_addr[31:0] = 32'h1000_0100; dfp_read = 2'b01; bmem_ready = 1'b1;
    tick();
    bmem_ready = 1'b0;
    send_beat(32'h1000_0100, 64'h11);
    send_beat(32'h1000_0100, 64'h22);
    rst = 1'b1; dfp_read = 2'b00;
    tick();
    rst = 1'b0;
    snap = resp_log.size();
    send_beat(32'h1000_0100, 64'h33);
    send_beat(32'h1000_0100, 64'h44);
    tick(); tick();
    @(negedge clk);
    check("rst_mid_no_resp", 512'(resp_log.size()), 512'(snap));
    check("rst_mid_err", err, 1'b0);
    check("rst_mid_buffer", dfp_rdata[LW-1:0], '0);
    dfp_read = 2'b01; bmem_ready = 1'b1;
    tick();
    bmem_ready = 1'b0;
    send_beat(32'h1000_0100, 64'h55);
    send_beat(32'h1000_0100, 64'h66);
    send_beat(32'h1000_0100, 64'h77);
    send_beat(32'h1000_0100, 64'h88);
    @(negedge clk);
    check("rst_mid_next_resp", dfp_resp, 2'b01);
    check("rst_mid_next_data", dfp_rdata[LW-1:0], {64'h88, 64'h77, 64'h66, 64'h55});
    dfp_read = 2'b00;
    tick();

    // Wide instance: simultaneous burst, then random traffic.
    tick(); tick();
    rst_b = 1'b0;
    @(negedge clk);
    check("b_rst_err", err_b, 1'b0);
    b_burst = 1;
    cyc = 0;
    while (b_done < NB && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    b_burst = 0;
    check("b_burst_timeout", 512'(cyc < 400), 512'd1);
    for (int k = 0; k < NB && k < b_order.size(); k++)
      check($sformatf("b_burst_grant%0d", k), 512'(b_order[k]), 512'(k));
    b_rand = 1;
    cyc = 0;
    while (b_done < NB + 60 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    b_rand = 0;
    check("b_random_timeout", 512'(cyc < 20000), 512'd1);
    cyc = 0;
    while ((b_active[0] || b_active[1] || b_active[2] || b_active[3]) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("b_drain_timeout", 512'(cyc < 2000), 512'd1);
    check("b_err_stays_clear", err_b, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
